// File: rtl/bp_cfg_link_endpoint.sv
// Config-link slave endpoint: decodes cfg commands against a base region, holds the tile's local
// control registers and forwards IRF/CSR/CCE-ucode accesses over one handshaked downstream channel.
module bp_cfg_link_endpoint #(
  parameter int                      addr_width_p    = 40,
  parameter int                      data_width_p    = 64,
  parameter logic [addr_width_p-1:0] base_addr_p     = 40'h00_0100_0000,
  parameter int                      core_id_width_p = 4,
  parameter int                      did_width_p     = 3,
  parameter int                      cord_width_p    = 7,
  parameter int                      mode_width_p    = 2,
  parameter int                      num_lce_width_p = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       cmd_v_i,
  output logic                       cmd_ready_o,
  input  logic                       cmd_w_i,
  input  logic [addr_width_p-1:0]    cmd_addr_i,
  input  logic [data_width_p-1:0]    cmd_data_i,
  output logic                       resp_v_o,
  input  logic                       resp_yumi_i,
  output logic [data_width_p-1:0]    resp_data_o,
  output logic                       resp_err_o,
  output logic                       reset_o,
  output logic                       freeze_o,
  output logic [core_id_width_p-1:0] core_id_o,
  output logic [did_width_p-1:0]     did_o,
  output logic [cord_width_p-1:0]    cord_o,
  output logic [did_width_p-1:0]     host_did_o,
  output logic [mode_width_p-1:0]    icache_mode_o,
  output logic [mode_width_p-1:0]    dcache_mode_o,
  output logic                       cce_mode_o,
  output logic [num_lce_width_p-1:0] num_lce_o,
  output logic                       npc_v_o,
  output logic [39:0]                npc_o,
  output logic                       fwd_v_o,
  input  logic                       fwd_ready_i,
  output logic [1:0]                 fwd_tgt_o,
  output logic                       fwd_w_o,
  output logic [11:0]                fwd_addr_o,
  output logic [data_width_p-1:0]    fwd_data_o,
  input  logic                       fwd_resp_v_i,
  input  logic [data_width_p-1:0]    fwd_resp_data_i
);

  localparam logic [1:0] state_idle     = 2'd0;
  localparam logic [1:0] state_fwd_req  = 2'd1;
  localparam logic [1:0] state_fwd_wait = 2'd2;
  localparam logic [1:0] state_resp     = 2'd3;

  localparam logic [3:0] sel_none     = 4'd0;
  localparam logic [3:0] sel_reset    = 4'd1;
  localparam logic [3:0] sel_freeze   = 4'd2;
  localparam logic [3:0] sel_core_id  = 4'd3;
  localparam logic [3:0] sel_did      = 4'd4;
  localparam logic [3:0] sel_cord     = 4'd5;
  localparam logic [3:0] sel_host_did = 4'd6;
  localparam logic [3:0] sel_icache   = 4'd7;
  localparam logic [3:0] sel_npc      = 4'd8;
  localparam logic [3:0] sel_dcache   = 4'd9;
  localparam logic [3:0] sel_cce      = 4'd10;
  localparam logic [3:0] sel_num_lce  = 4'd11;

  localparam logic [1:0] tgt_irf   = 2'd0;
  localparam logic [1:0] tgt_csr   = 2'd1;
  localparam logic [1:0] tgt_ucode = 2'd2;

  logic [1:0]                 state_r;
  logic                       reset_r, freeze_r, cce_mode_r, npc_v_r, fwd_w_r, resp_err_r;
  logic [core_id_width_p-1:0] core_id_r;
  logic [did_width_p-1:0]     did_r, host_did_r;
  logic [cord_width_p-1:0]    cord_r;
  logic [mode_width_p-1:0]    icache_mode_r, dcache_mode_r;
  logic [num_lce_width_p-1:0] num_lce_r;
  logic [39:0]                npc_r;
  logic [1:0]                 fwd_tgt_r;
  logic [11:0]                fwd_addr_r;
  logic [data_width_p-1:0]    fwd_data_r, resp_data_r;

  logic [15:0]                off_s;
  logic                       region_hit_s, fwd_hit_s;
  logic [3:0]                 loc_sel_s;
  logic [1:0]                 fwd_tgt_s;
  logic [11:0]                fwd_off_s;
  logic [data_width_p-1:0]    rd_data_s;

  assign off_s        = cmd_addr_i[15:0];
  assign region_hit_s = (cmd_addr_i[addr_width_p-1:16] == base_addr_p[addr_width_p-1:16]);

  // Address decode: local register select or forwarded target/offset.
  always_comb begin
    loc_sel_s = sel_none;
    fwd_hit_s = 1'b0;
    fwd_tgt_s = tgt_irf;
    fwd_off_s = 12'h000;
    if (region_hit_s) begin
      case (off_s)
        16'h0001: loc_sel_s = sel_reset;
        16'h0002: loc_sel_s = sel_freeze;
        16'h0005: loc_sel_s = sel_core_id;
        16'h0006: loc_sel_s = sel_did;
        16'h0007: loc_sel_s = sel_cord;
        16'h0008: loc_sel_s = sel_host_did;
        16'h0022: loc_sel_s = sel_icache;
        16'h0040: loc_sel_s = sel_npc;
        16'h0043: loc_sel_s = sel_dcache;
        16'h0081: loc_sel_s = sel_cce;
        16'h0082: loc_sel_s = sel_num_lce;
        default: begin
          if ((off_s >= 16'h0050) && (off_s <= 16'h006F)) begin
            fwd_hit_s = 1'b1;
            fwd_tgt_s = tgt_irf;
            fwd_off_s = off_s[11:0] - 12'h050;
          end else if (off_s[15:12] == 4'h6) begin
            fwd_hit_s = 1'b1;
            fwd_tgt_s = tgt_csr;
            fwd_off_s = off_s[11:0];
          end else if (off_s[15:12] == 4'h8) begin
            fwd_hit_s = 1'b1;
            fwd_tgt_s = tgt_ucode;
            fwd_off_s = off_s[11:0];
          end else begin
            fwd_hit_s = 1'b0;
          end
        end
      endcase
    end else begin
      loc_sel_s = sel_none;
    end
  end

  // Local register read mux, zero-extended to the response width.
  always_comb begin
    rd_data_s = {data_width_p{1'b0}};
    case (loc_sel_s)
      sel_reset:    rd_data_s[0]                   = reset_r;
      sel_freeze:   rd_data_s[0]                   = freeze_r;
      sel_core_id:  rd_data_s[core_id_width_p-1:0] = core_id_r;
      sel_did:      rd_data_s[did_width_p-1:0]     = did_r;
      sel_cord:     rd_data_s[cord_width_p-1:0]    = cord_r;
      sel_host_did: rd_data_s[did_width_p-1:0]     = host_did_r;
      sel_icache:   rd_data_s[mode_width_p-1:0]    = icache_mode_r;
      sel_npc:      rd_data_s[39:0]                = npc_r;
      sel_dcache:   rd_data_s[mode_width_p-1:0]    = dcache_mode_r;
      sel_cce:      rd_data_s[0]                   = cce_mode_r;
      sel_num_lce:  rd_data_s[num_lce_width_p-1:0] = num_lce_r;
      default:      rd_data_s                      = {data_width_p{1'b0}};
    endcase
  end

  // Command FSM, local register file and response/forward holding registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r       <= state_idle;
      reset_r       <= 1'b1;
      freeze_r      <= 1'b1;
      core_id_r     <= {core_id_width_p{1'b0}};
      did_r         <= {did_width_p{1'b0}};
      cord_r        <= {cord_width_p{1'b0}};
      host_did_r    <= {did_width_p{1'b0}};
      icache_mode_r <= {mode_width_p{1'b0}};
      dcache_mode_r <= {mode_width_p{1'b0}};
      cce_mode_r    <= 1'b0;
      num_lce_r     <= {num_lce_width_p{1'b0}};
      npc_r         <= 40'h00_0000_0000;
      npc_v_r       <= 1'b0;
      fwd_tgt_r     <= tgt_irf;
      fwd_w_r       <= 1'b0;
      fwd_addr_r    <= 12'h000;
      fwd_data_r    <= {data_width_p{1'b0}};
      resp_data_r   <= {data_width_p{1'b0}};
      resp_err_r    <= 1'b0;
    end else begin
      npc_v_r <= 1'b0;
      case (state_r)
        state_idle: begin
          if (cmd_v_i) begin
            if (fwd_hit_s) begin
              fwd_tgt_r  <= fwd_tgt_s;
              fwd_w_r    <= cmd_w_i;
              fwd_addr_r <= fwd_off_s;
              fwd_data_r <= cmd_data_i;
              state_r    <= state_fwd_req;
            end else begin
              // Unmapped reads already see zero from the mux; writes always answer zero.
              resp_data_r <= cmd_w_i ? {data_width_p{1'b0}} : rd_data_s;
              resp_err_r  <= (loc_sel_s == sel_none);
              state_r     <= state_resp;
              if (cmd_w_i) begin
                case (loc_sel_s)
                  sel_reset:    reset_r       <= cmd_data_i[0];
                  sel_freeze:   freeze_r      <= cmd_data_i[0];
                  sel_core_id:  core_id_r     <= cmd_data_i[core_id_width_p-1:0];
                  sel_did:      did_r         <= cmd_data_i[did_width_p-1:0];
                  sel_cord:     cord_r        <= cmd_data_i[cord_width_p-1:0];
                  sel_host_did: host_did_r    <= cmd_data_i[did_width_p-1:0];
                  sel_icache:   icache_mode_r <= cmd_data_i[mode_width_p-1:0];
                  sel_dcache:   dcache_mode_r <= cmd_data_i[mode_width_p-1:0];
                  sel_cce:      cce_mode_r    <= cmd_data_i[0];
                  sel_num_lce:  num_lce_r     <= cmd_data_i[num_lce_width_p-1:0];
                  sel_npc: begin
                    npc_r   <= cmd_data_i[39:0];
                    npc_v_r <= 1'b1;
                  end
                  default:      npc_v_r       <= 1'b0;
                endcase
              end
            end
          end
        end
        state_fwd_req: begin
          if (fwd_ready_i) state_r <= state_fwd_wait;
        end
        state_fwd_wait: begin
          if (fwd_resp_v_i) begin
            resp_data_r <= fwd_w_r ? {data_width_p{1'b0}} : fwd_resp_data_i;
            resp_err_r  <= 1'b0;
            state_r     <= state_resp;
          end
        end
        state_resp: begin
          if (resp_yumi_i) state_r <= state_idle;
        end
        default: state_r <= state_idle;
      endcase
    end
  end

  assign cmd_ready_o   = (state_r == state_idle);
  assign resp_v_o      = (state_r == state_resp);
  assign fwd_v_o       = (state_r == state_fwd_req);
  assign resp_data_o   = resp_data_r;
  assign resp_err_o    = resp_err_r;
  assign reset_o       = reset_r;
  assign freeze_o      = freeze_r;
  assign core_id_o     = core_id_r;
  assign did_o         = did_r;
  assign cord_o        = cord_r;
  assign host_did_o    = host_did_r;
  assign icache_mode_o = icache_mode_r;
  assign dcache_mode_o = dcache_mode_r;
  assign cce_mode_o    = cce_mode_r;
  assign num_lce_o     = num_lce_r;
  assign npc_v_o       = npc_v_r;
  assign npc_o         = npc_r;
  assign fwd_tgt_o     = fwd_tgt_r;
  assign fwd_w_o       = fwd_w_r;
  assign fwd_addr_o    = fwd_addr_r;
  assign fwd_data_o    = fwd_data_r;

endmodule

// File: tb/tb_bp_cfg_link_endpoint.sv
// Self-checking bench for bp_cfg_link_endpoint: directed vector table, hand-written corner
// sequences and randomized commands against a register/memory reference model.
module tb_bp_cfg_link_endpoint;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        cmd_v_i = 1'b0, cmd_ready_o, cmd_w_i = 1'b0;
  logic [39:0] cmd_addr_i = 40'h0;
  logic [63:0] cmd_data_i = 64'h0;
  logic        resp_v_o, resp_yumi_i = 1'b0, resp_err_o;
  logic [63:0] resp_data_o;
  logic        reset_o, freeze_o, cce_mode_o, npc_v_o;
  logic [3:0]  core_id_o, num_lce_o;
  logic [2:0]  did_o, host_did_o;
  logic [6:0]  cord_o;
  logic [1:0]  icache_mode_o, dcache_mode_o, fwd_tgt_o;
  logic [39:0] npc_o;
  logic        fwd_v_o, fwd_ready_i, fwd_w_o, fwd_resp_v_i;
  logic [11:0] fwd_addr_o;
  logic [63:0] fwd_data_o, fwd_resp_data_i;
  logic [67:0] out_regs;

  bp_cfg_link_endpoint dut (
    .clk_i(clk), .reset_i(reset_i), .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o),
    .cmd_w_i(cmd_w_i), .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i),
    .resp_v_o(resp_v_o), .resp_yumi_i(resp_yumi_i), .resp_data_o(resp_data_o),
    .resp_err_o(resp_err_o), .reset_o(reset_o), .freeze_o(freeze_o), .core_id_o(core_id_o),
    .did_o(did_o), .cord_o(cord_o), .host_did_o(host_did_o), .icache_mode_o(icache_mode_o),
    .dcache_mode_o(dcache_mode_o), .cce_mode_o(cce_mode_o), .num_lce_o(num_lce_o),
    .npc_v_o(npc_v_o), .npc_o(npc_o), .fwd_v_o(fwd_v_o), .fwd_ready_i(fwd_ready_i),
    .fwd_tgt_o(fwd_tgt_o), .fwd_w_o(fwd_w_o), .fwd_addr_o(fwd_addr_o), .fwd_data_o(fwd_data_o),
    .fwd_resp_v_i(fwd_resp_v_i), .fwd_resp_data_i(fwd_resp_data_i)
  );

  assign out_regs = {reset_o, freeze_o, core_id_o, did_o, cord_o, host_did_o, icache_mode_o,
                     dcache_mode_o, cce_mode_o, num_lce_o, npc_o};

  initial forever #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: local registers by table position, downstream memory by {target, offset}.
  int          loc_off [11] = '{32'h01, 32'h02, 32'h05, 32'h06, 32'h07, 32'h08,
                                32'h22, 32'h40, 32'h43, 32'h81, 32'h82};
  int          loc_wid [11] = '{1, 1, 4, 3, 7, 3, 2, 40, 2, 1, 4};
  logic [63:0] mreg [11];
  logic [63:0] exp_mem [int];
  logic [63:0] ds_mem [int];

  function automatic logic [63:0] mem_init(input int key);
    logic [15:0] k;
    k = key[15:0];
    return {16'hA5A5, k, 16'h5A5A, ~k};
  endfunction

  function automatic logic [67:0] exp_regs();
    return {mreg[0][0], mreg[1][0], mreg[2][3:0], mreg[3][2:0], mreg[4][6:0], mreg[5][2:0],
            mreg[6][1:0], mreg[8][1:0], mreg[9][0], mreg[10][3:0], mreg[7][39:0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 11; i++) mreg[i] = 64'h0;
    mreg[0] = 64'h1;
    mreg[1] = 64'h1;
  endtask

  // kind: 0 local, 1 forwarded, 2 error
  task automatic model_cmd(input logic w, input logic [39:0] a, input logic [63:0] d,
                           output int kind, output logic [63:0] edata, output int tgt, output int faddr);
    int off;
    int key;
    off = int'(a[15:0]);
    kind = 2; edata = 64'h0; tgt = 0; faddr = 0;
    if (a[39:16] != 24'h000100) return;
    for (int i = 0; i < 11; i++) begin
      if (off == loc_off[i]) begin
        kind = 0;
        if (w) mreg[i] = d & ((64'd1 << loc_wid[i]) - 64'd1);
        else edata = mreg[i];
        return;
      end
    end
    if (off >= 32'h50 && off <= 32'h6F) begin kind = 1; tgt = 0; faddr = off - 32'h50; end
    else if (off >= 32'h6000 && off <= 32'h6FFF) begin kind = 1; tgt = 1; faddr = off - 32'h6000; end
    else if (off >= 32'h8000 && off <= 32'h8FFF) begin kind = 1; tgt = 2; faddr = off - 32'h8000; end
    if (kind == 1) begin
      key = tgt * 4096 + faddr;
      if (w) exp_mem[key] = d;
      else edata = exp_mem.exists(key) ? exp_mem[key] : mem_init(key);
    end
  endtask

  // Downstream responder with programmable ready and completion delays.
  int          rdy_delay = 0, resp_delay = 0, ds_count = 0;
  int          ds_tgt, ds_addr, ds_key;
  logic        ds_w;
  logic [63:0] ds_wdata;
  initial begin
    int cnt;
    bit pend;
    cnt = 0; pend = 1'b0;
    fwd_ready_i = 1'b0; fwd_resp_v_i = 1'b0; fwd_resp_data_i = 64'h0;
    forever begin
      @(negedge clk);
      fwd_ready_i = 1'b0;
      fwd_resp_v_i = 1'b0;
      if (reset_i) begin
        pend = 1'b0; cnt = 0;
      end else if (pend) begin
        if (cnt >= resp_delay) begin
          fwd_resp_v_i = 1'b1;
          if (ds_w) begin
            fwd_resp_data_i = 64'hBAD0_BAD0_BAD0_BAD0;
            ds_mem[ds_key] = ds_wdata;
          end else begin
            fwd_resp_data_i = ds_mem.exists(ds_key) ? ds_mem[ds_key] : mem_init(ds_key);
          end
          pend = 1'b0; cnt = 0;
        end else cnt++;
      end else if (fwd_v_o) begin
        if (cnt >= rdy_delay) begin
          fwd_ready_i = 1'b1;
          ds_tgt = int'(fwd_tgt_o); ds_addr = int'(fwd_addr_o); ds_w = fwd_w_o;
          ds_wdata = fwd_data_o; ds_key = ds_tgt * 4096 + ds_addr;
          ds_count++;
          pend = 1'b1; cnt = 0;
        end else cnt++;
      end
    end
  end

  // Monitors: fwd_v_o run length / field stability, npc_v_o pulses.
  int          fwd_len = 0, fwd_run = 0, fwd_unstable = 0, npc_pulses = 0;
  logic [78:0] fwd_snap;
  logic [39:0] npc_seen = 40'h0;
  initial begin
    bit fwd_in;
    fwd_in = 1'b0;
    forever begin
      @(negedge clk);
      if (fwd_v_o) begin
        if (!fwd_in) begin
          fwd_snap = {fwd_tgt_o, fwd_w_o, fwd_addr_o, fwd_data_o};
          fwd_run = 1;
        end else begin
          fwd_run++;
          if ({fwd_tgt_o, fwd_w_o, fwd_addr_o, fwd_data_o} !== fwd_snap) fwd_unstable++;
        end
      end else if (fwd_in) fwd_len = fwd_run;
      fwd_in = fwd_v_o;
      if (npc_v_o) begin npc_pulses++; npc_seen = npc_o; end
    end
  end

  task automatic do_cmd(input logic w, input logic [39:0] a, input logic [63:0] d, input int yd,
                        output logic [63:0] rd, output logic er, output int lat,
                        output logic [67:0] regs, output int unst);
    int n;
    rd = 64'h0; er = 1'b0; lat = 0; regs = 68'h0; unst = 0;
    @(negedge clk);
    cmd_v_i = 1'b1; cmd_w_i = w; cmd_addr_i = a; cmd_data_i = d;
    n = 0;
    while (!cmd_ready_o && n < 40) begin @(negedge clk); n++; end
    check("cmd_ready", cmd_ready_o, 1);
    if (!cmd_ready_o) begin cmd_v_i = 1'b0; return; end
    @(negedge clk);
    cmd_v_i = 1'b0;
    lat = 1;
    while (!resp_v_o && lat < 60) begin @(negedge clk); lat++; end
    check("resp_v", resp_v_o, 1);
    if (!resp_v_o) return;
    rd = resp_data_o; er = resp_err_o; regs = out_regs;
    for (int i = 0; i < yd; i++) begin
      @(negedge clk);
      if (!resp_v_o || resp_data_o !== rd || resp_err_o !== er || cmd_ready_o) unst++;
    end
    resp_yumi_i = 1'b1;
    @(negedge clk);
    resp_yumi_i = 1'b0;
  endtask

  task automatic run_op(input logic w, input logic [39:0] a, input logic [63:0] d, input int yd,
                        output logic [63:0] rd, output logic er);
    int kind, tgt, faddr, lat, unst, cnt0;
    logic [63:0] edata;
    logic [67:0] regs;
    cnt0 = ds_count;
    model_cmd(w, a, d, kind, edata, tgt, faddr);
    do_cmd(w, a, d, yd, rd, er, lat, regs, unst);
    check("resp_data", rd, edata);
    check("resp_err", er, (kind == 2) ? 128'd1 : 128'd0);
    check("latency", lat, (kind == 1) ? 128'(3 + rdy_delay + resp_delay) : 128'd1);
    check("regs_at_resp", regs, exp_regs());
    check("resp_hold", unst, 0);
    check("fwd_count", ds_count - cnt0, (kind == 1) ? 128'd1 : 128'd0);
    if (kind == 1) begin
      check("fwd_tgt", ds_tgt, tgt);
      check("fwd_addr", ds_addr, faddr);
      check("fwd_w", ds_w, w);
      if (w) check("fwd_data", ds_wdata, d);
    end
  endtask

  typedef struct {
    logic        w;
    logic [39:0] addr;
    logic [63:0] data;
    logic [63:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t tbl [15];

  initial begin
    logic [63:0] rd;
    logic        er;
    int          n;
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd;
    logic        er;
    logic [39:0] a;
    logic [15:0] off;
    logic [15:0] bad_offs [10];
    int          n;
    bad_offs = '{16'h0000, 16'h0003, 16'h0004, 16'h004F, 16'h0070,
                 16'h5FFF, 16'h7000, 16'h9000, 16'hFFFF, 16'h0041};

    tbl[0]  = '{1'b1, 40'h00_0100_0001, 64'h0,     64'h0,  1'b0};
    tbl[1]  = '{1'b1, 40'h00_0100_0007, 64'h1FF,   64'h0,  1'b0};
    tbl[2]  = '{1'b0, 40'h00_0100_0007, 64'h0,     64'h7F, 1'b0};
    tbl[3]  = '{1'b1, 40'h00_0100_0002, 64'h0,     64'h0,  1'b0};
    tbl[4]  = '{1'b0, 40'h00_0100_0002, 64'h0,     64'h0,  1'b0};
    tbl[5]  = '{1'b1, 40'h00_0100_0005, 64'hAB,    64'h0,  1'b0};
    tbl[6]  = '{1'b0, 40'h00_0100_0005, 64'h0,     64'hB,  1'b0};
    tbl[7]  = '{1'b0, 40'h00_0200_0001, 64'h0,     64'h0,  1'b1};
    tbl[8]  = '{1'b0, 40'h00_0100_0003, 64'h0,     64'h0,  1'b1};
    tbl[9]  = '{1'b1, 40'h00_0100_0003, 64'hFF,    64'h0,  1'b1};
    tbl[10] = '{1'b1, 40'h00_0100_0081, 64'h3,     64'h0,  1'b0};
    tbl[11] = '{1'b0, 40'h00_0100_0081, 64'h0,     64'h1,  1'b0};
    tbl[12] = '{1'b1, 40'h00_0100_0082, 64'h1F,    64'h0,  1'b0};
    tbl[13] = '{1'b0, 40'h00_0100_0082, 64'h0,     64'hF,  1'b0};
    tbl[14] = '{1'b0, 40'h00_0100_0001, 64'h0,     64'h0,  1'b0};

    model_reset();
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    check("rst_reset_o", reset_o, 1);
    check("rst_freeze_o", freeze_o, 1);
    check("rst_cmd_ready", cmd_ready_o, 1);
    check("rst_resp_v", resp_v_o, 0);
    check("rst_fwd_v", fwd_v_o, 0);
    check("rst_npc_v", npc_v_o, 0);
    check("rst_regs", out_regs, exp_regs());

    for (int i = 0; i < 15; i++) begin
      run_op(tbl[i].w, tbl[i].addr, tbl[i].data, 0, rd, er);
      check($sformatf("tbl%0d_data", i), rd, tbl[i].exp_data);
      check($sformatf("tbl%0d_err", i), er, tbl[i].exp_err);
    end
    check("cord_trunc", cord_o, 7'h7F);

    npc_pulses = 0;
    run_op(1'b1, 40'h00_0100_0040, 64'h8000_0000, 0, rd, er);
    repeat (3) @(negedge clk);
    check("npc_pulses", npc_pulses, 1);
    check("npc_at_pulse", npc_seen, 40'h00_8000_0000);
    run_op(1'b0, 40'h00_0100_0040, 64'h0, 0, rd, er);
    check("npc_read", rd, 64'h8000_0000);

    ds_mem[5] = 64'hDEAD;
    exp_mem[5] = 64'hDEAD;
    fwd_unstable = 0;
    rdy_delay = 3;
    run_op(1'b0, 40'h00_0100_0055, 64'h0, 0, rd, er);
    check("irf_rd_data", rd, 64'hDEAD);
    check("irf_fwd_len", fwd_len, 4);
    check("irf_fwd_stable", fwd_unstable, 0);
    check("irf_snap", fwd_snap[78:64], {2'd0, 1'b0, 12'h005});
    rdy_delay = 0;

    run_op(1'b1, 40'h00_0100_8010, 64'h1234_5678, 5, rd, er);
    check("ucode_tgt", ds_tgt, 2);
    check("ucode_addr", ds_addr, 12'h010);

    for (int it = 0; it < 150; it++) begin
      n = $urandom_range(0, 6);
      if (n <= 1) off = loc_off[$urandom_range(0, 10)][15:0];
      else if (n == 2) off = 16'h0050 + 16'($urandom_range(0, 31));
      else if (n == 3) off = 16'h6000 + 16'($urandom_range(0, 4095));
      else if (n == 4) off = 16'h8000 + 16'($urandom_range(0, 4095));
      else if (n == 5) off = bad_offs[$urandom_range(0, 9)];
      else off = loc_off[$urandom_range(0, 10)][15:0];
      a = {24'h000100, off};
      if (n == 6) a[39:16] = 24'h000100 ^ (24'h1 << $urandom_range(0, 23));
      rdy_delay = $urandom_range(0, 3);
      resp_delay = $urandom_range(0, 3);
      run_op(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, $urandom_range(0, 3), rd, er);
    end
    rdy_delay = 0;

    // Reset while waiting on downstream completion: command is dropped without a response.
    resp_delay = 30;
    @(negedge clk);
    cmd_v_i = 1'b1; cmd_w_i = 1'b0; cmd_addr_i = 40'h00_0100_6123;
    @(negedge clk);
    cmd_v_i = 1'b0;
    @(negedge clk);
    check("pre_rst_fwd_v", fwd_v_o, 0);
    check("pre_rst_resp_v", resp_v_o, 0);
    reset_i = 1'b1;
    @(negedge clk);
    check("rst_mid_fwd_v", fwd_v_o, 0);
    check("rst_mid_resp_v", resp_v_o, 0);
    @(negedge clk);
    reset_i = 1'b0;
    model_reset();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_v_o || !cmd_ready_o) n++;
    end
    check("rst_no_resp", n, 0);
    check("rst_mid_regs", out_regs, exp_regs());
    resp_delay = 0;
    run_op(1'b0, 40'h00_0100_0007, 64'h0, 0, rd, er);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bp_cfg_link_endpoint.md
Name: bp_cfg_link_endpoint

Overview:
- Parametrised config-link slave that replaces the fixed cfg address map with a decoded, handshaked register endpoint.
- Accepts one cfg command at a time and checks it against a parametrised base and region.
- Local registers (reset, freeze, ids, modes, npc) are held in the block; IRF, CSR and CCE-ucode ranges are forwarded on a single downstream channel.
- Every command gets one response with data and an error flag. Sits between the host/NoC cfg adapter and each tile's core/cache/CCE.

Parameters:
- addr_width_p, 40, command address width.
- data_width_p, 64, command/response data width (must be >= 40 and >= cord_width_p).
- base_addr_p, 'h0100_0000, region base; hit when addr[addr_width_p-1:16] == base_addr_p[addr_width_p-1:16].
- core_id_width_p, 4, core_id register width.
- did_width_p, 3, did and host_did register width.
- cord_width_p, 7, cord register width.
- mode_width_p, 2, icache_mode and dcache_mode register width.
- num_lce_width_p, 4, num_lce register width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- cmd_v_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when cmd_v_i & cmd_ready_o.
- cmd_w_i  in  1  1 = write, 0 = read.
- cmd_addr_i  in  addr_width_p  byte-independent register address.
- cmd_data_i  in  data_width_p  write data.
- resp_v_o  out  1  response valid.
- resp_yumi_i  in  1  response consumed.
- resp_data_o  out  data_width_p  read data, zero-extended; 0 for writes.
- resp_err_o  out  1  unmapped or out-of-region access.
- reset_o  out  1  tile reset register.
- freeze_o  out  1  tile freeze register.
- core_id_o  out  core_id_width_p  core id register.
- did_o  out  did_width_p  domain id register.
- cord_o  out  cord_width_p  coordinate register.
- host_did_o  out  did_width_p  host domain id register.
- icache_mode_o  out  mode_width_p  icache mode register.
- dcache_mode_o  out  mode_width_p  dcache mode register.
- cce_mode_o  out  1  cce mode register.
- num_lce_o  out  num_lce_width_p  num_lce register.
- npc_v_o  out  1  one-cycle pulse on npc write.
- npc_o  out  40  last written npc.
- fwd_v_o  out  1  forwarded request valid.
- fwd_ready_i  in  1  forwarded request accepted.
- fwd_tgt_o  out  2  0 = irf, 1 = csr, 2 = ucode.
- fwd_w_o  out  1  forwarded request is a write.
- fwd_addr_o  out  12  offset within the target range.
- fwd_data_o  out  data_width_p  forwarded write data.
- fwd_resp_v_i  in  1  downstream completion (read data or write ack).
- fwd_resp_data_i  in  data_width_p  downstream read data.

Behaviour:
- Reset values:
  - reset_o = 1, freeze_o = 1; all other registers, npc_o, npc_v_o, fwd_v_o and resp_v_o = 0.
  - FSM enters IDLE and any in-flight command is dropped silently.
- Offset map, off = cmd_addr_i[15:0]:
  - 0x0001 reset, 0x0002 freeze, 0x0005 core_id, 0x0006 did, 0x0007 cord, 0x0008 host_did.
  - 0x0022 icache_mode, 0x0040 npc, 0x0043 dcache_mode, 0x0081 cce_mode, 0x0082 num_lce.
  - 0x0050-0x006F irf: fwd_addr = off - 0x50.
  - 0x6000-0x6FFF csr: fwd_addr = off[11:0].
  - 0x8000-0x8FFF ucode: fwd_addr = off[11:0].
- Writes take the low bits of cmd_data_i. Reads return the zero-extended register value.
- FSM states: IDLE, FWD_REQ, FWD_WAIT, RESP.
- IDLE:
  - cmd_ready_o = 1 in IDLE only.
  - On accept of a local or unmapped command: the register update is visible on outputs the next cycle; go to RESP with data/err latched.
  - On accept of a forwarded command: latch the fwd fields and go to FWD_REQ.
- FWD_REQ: fwd_v_o = 1 with stable fields until fwd_ready_i; then go to FWD_WAIT.
- FWD_WAIT:
  - Wait for fwd_resp_v_i; capture fwd_resp_data_i for reads (0 for writes); go to RESP.
  - fwd_resp_v_i outside FWD_WAIT is ignored.
- RESP: resp_v_o = 1, data/err held stable until resp_yumi_i; then go to IDLE (next accept is possible in the following cycle).
- npc write: npc_v_o pulses exactly one cycle, coincident with the first cycle npc_o shows the new value.
- Out-of-region or unmapped offset:
  - No state change and nothing forwarded.
  - Response has resp_err_o = 1 and resp_data_o = 0, for both reads and writes.
- Minimum latency: local command accepted in cycle t gives resp_v_o in t+1; forwarded command with immediate downstream gives resp_v_o in t+3.
- reset_i asserted mid-transaction overrides everything: fwd_v_o and resp_v_o drop the next cycle, with no response for the dropped command.

Test Plan:
- Out of reset -> reset_o = 1, freeze_o = 1, cmd_ready_o = 1. Write 0x0100_0001 = 0 -> reset_o = 0 next cycle, resp_v_o = 1, resp_err_o = 0.
- Write 0x0100_0040 = 0x80000000 -> npc_v_o high for exactly 1 cycle, npc_o = 0x80000000. Read 0x0100_0040 -> resp_data_o = 0x80000000.
- Write 0x0100_0007 = 0x1FF -> cord_o = 0x7F (truncation). Read back -> 0x7F.
- Read 0x0100_0055, fwd_ready_i delayed 3 cycles, fwd_resp_data_i = 0xDEAD -> fwd_tgt_o = 0, fwd_addr_o = 5, fwd_v_o held 4 cycles, resp_data_o = 0xDEAD.
- Write 0x0100_8010 with resp_yumi_i low for 5 cycles -> fwd_tgt_o = 2, fwd_addr_o = 0x010; resp held stable 5 cycles; cmd_ready_o = 0 until yumi.
- Read 0x0200_0001 and 0x0100_0003 -> resp_err_o = 1, resp_data_o = 0. Assert reset_i in FWD_WAIT -> IDLE, no response, registers at reset values.
